util_tx_burst_sched: RTL and testbench

//  Timed-transmit scheduler on dac_clk, between DMA-side 64-bit TX stream and the sample unpacker.

---
 rtl/util_tx_sched_pkg.sv | 22 ++
 rtl/util_tx_sched_ts_cmp.sv | 40 ++++
 rtl/util_tx_burst_sched.sv | 181 ++++++++++++++++++
 tb/tb_util_tx_burst_sched.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/util_tx_sched_pkg.sv
// Shared types and constants for the timed-transmit burst scheduler.
// Consumed by util_tx_burst_sched and util_tx_sched_ts_cmp.
package util_tx_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BYPASS = 3'd1,
        ST_HDR    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_PASS   = 3'd4,
        ST_DROP   = 3'd5
    } sched_state_e;

    // Header value minus current timestamp that still lets the first beat leave exactly on time.
    localparam int TS_DIFF_ON_TIME = 1;

    localparam int HDR_DATA_WIDTH = 64;
    localparam int HDR_TS_WIDTH   = 64;
    localparam int BEAT_CNT_WIDTH = 32;
    localparam int STAT_CNT_WIDTH = 32;

endpackage

// File: rtl/util_tx_sched_ts_cmp.sv
// Header timestamp register plus wrap-safe signed comparison against the DAC timestamp.
// Flags classify an incoming header; release_next fires one cycle before the held header time.
module util_tx_sched_ts_cmp
    import util_tx_sched_pkg::*;
#(
    parameter int TS_WIDTH = HDR_TS_WIDTH
) (
    input  logic                dac_clk,
    input  logic                reset,
    input  logic                load,
    input  logic [TS_WIDTH-1:0] hdr_ts,
    input  logic [TS_WIDTH-1:0] timestamp,
    output logic                hdr_late,
    output logic                hdr_on_time,
    output logic                hdr_early,
    output logic                release_next
);

    logic [TS_WIDTH-1:0] ts_q;
    logic [TS_WIDTH-1:0] hdr_diff;
    logic [TS_WIDTH-1:0] wait_diff;

    always_ff @(posedge dac_clk) begin
        if (reset) begin
            ts_q <= '0;
        end else if (load) begin
            ts_q <= hdr_ts;
        end
    end

    // Modular subtraction; the sign bit separates past from future across counter wrap.
    assign hdr_diff    = hdr_ts - timestamp;
    assign hdr_late    = hdr_diff[TS_WIDTH-1] || (hdr_diff == '0);
    assign hdr_on_time = (hdr_diff == TS_WIDTH'(TS_DIFF_ON_TIME));
    assign hdr_early   = !hdr_late && !hdr_on_time;

    assign wait_diff    = ts_q - timestamp;
    assign release_next = (wait_diff == TS_WIDTH'(TS_DIFF_ON_TIME));

endmodule

// File: rtl/util_tx_burst_sched.sv
// Timed-transmit scheduler: holds each header-tagged group until the DAC timestamp reaches it.
// Define UTIL_TX_SCHED_STATS_EN to add saturating late_count / underflow_count outputs.
//
// state  | meaning
// IDLE   | no transfer; latch timestamp_every when xfer_req rises
// BYPASS | timestamp_every==0, stream passes straight through
// HDR    | expecting a header word
// WAIT   | header early, input stalled until its timestamp
// PASS   | releasing the group beat-for-beat
// DROP   | header late, swallowing the group
module util_tx_burst_sched
    import util_tx_sched_pkg::*;
#(
    parameter int DATA_WIDTH = HDR_DATA_WIDTH,
    parameter int TS_WIDTH   = HDR_TS_WIDTH,
    parameter int CNT_WIDTH  = BEAT_CNT_WIDTH
) (
    input  logic                  dac_clk,
    input  logic                  reset,
    input  logic [TS_WIDTH-1:0]   timestamp,
    input  logic [CNT_WIDTH-1:0]  timestamp_every,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic                  s_axis_xfer_req,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  upack_flush,
    output logic                  late,
    output logic                  underflow
`ifdef UTIL_TX_SCHED_STATS_EN
    ,
    output logic [STAT_CNT_WIDTH-1:0] late_count,
    output logic [STAT_CNT_WIDTH-1:0] underflow_count
`endif
);

    sched_state_e         state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic [CNT_WIDTH-1:0] every_q, every_nxt;
    logic                 late_nxt, flush_nxt, underflow_nxt;
    logic                 ts_load, beat_acc, group_last;
    logic                 hdr_late, hdr_on_time, hdr_early, release_next;

    assign m_axis_data = s_axis_data;
    assign group_last  = (cnt == every_q - CNT_WIDTH'(1));

    util_tx_sched_ts_cmp #(
        .TS_WIDTH (TS_WIDTH)
    ) u_ts_cmp (
        .dac_clk      (dac_clk),
        .reset        (reset),
        .load         (ts_load),
        .hdr_ts       (s_axis_data[TS_WIDTH-1:0]),
        .timestamp    (timestamp),
        .hdr_late     (hdr_late),
        .hdr_on_time  (hdr_on_time),
        .hdr_early    (hdr_early),
        .release_next (release_next)
    );

    always_ff @(posedge dac_clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            every_q     <= '0;
            upack_flush <= 1'b0;
            late        <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            every_q     <= every_nxt;
            upack_flush <= flush_nxt;
            late        <= late_nxt;
            underflow   <= underflow_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        every_nxt     = every_q;
        late_nxt      = 1'b0;
        flush_nxt     = 1'b0;
        underflow_nxt = 1'b0;
        ts_load       = 1'b0;
        beat_acc      = 1'b0;
        s_axis_ready  = 1'b0;
        m_axis_valid  = 1'b0;
        if (!s_axis_xfer_req) begin
            // Abort: the unpacker may hold a partial group only if we were inside one.
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            flush_nxt = (state == ST_PASS) || (state == ST_DROP);
        end else begin
            case (state)
                ST_IDLE: begin
                    every_nxt = timestamp_every;
                    state_nxt = (timestamp_every == '0) ? ST_BYPASS : ST_HDR;
                end
                ST_BYPASS: begin
                    s_axis_ready = m_axis_ready;
                    m_axis_valid = s_axis_valid;
                end
                ST_HDR: begin
                    s_axis_ready = 1'b1;
                    cnt_nxt      = '0;
                    if (s_axis_valid) begin
                        ts_load = 1'b1;
                        if (hdr_on_time) begin
                            state_nxt = ST_PASS;
                        end else if (hdr_early) begin
                            state_nxt = ST_WAIT;
                        end else begin
                            state_nxt = ST_DROP;
                            late_nxt  = hdr_late;
                            flush_nxt = hdr_late;
                        end
                    end
                end
                ST_WAIT: begin
                    if (release_next) begin
                        state_nxt = ST_PASS;
                    end
                end
                ST_PASS: begin
                    m_axis_valid  = s_axis_valid;
                    s_axis_ready  = m_axis_ready;
                    underflow_nxt = m_axis_ready && !s_axis_valid;
                    beat_acc      = s_axis_valid && m_axis_ready;
                end
                ST_DROP: begin
                    s_axis_ready = 1'b1;
                    beat_acc     = s_axis_valid;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase

            // Group boundary: new timestamp_every is picked up only here.
            if (beat_acc) begin
                if (group_last) begin
                    cnt_nxt   = '0;
                    every_nxt = timestamp_every;
                    state_nxt = (timestamp_every == '0) ? ST_BYPASS : ST_HDR;
                end else begin
                    cnt_nxt = cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

`ifdef UTIL_TX_SCHED_STATS_EN
    logic xfer_req_q;

    always_ff @(posedge dac_clk) begin
        if (reset) begin
            xfer_req_q      <= 1'b0;
            late_count      <= '0;
            underflow_count <= '0;
        end else begin
            xfer_req_q <= s_axis_xfer_req;
            if (s_axis_xfer_req && !xfer_req_q) begin
                late_count      <= '0;
                underflow_count <= '0;
            end else begin
                if (late_nxt && (late_count != '1)) begin
                    late_count <= late_count + STAT_CNT_WIDTH'(1);
                end
                if (underflow_nxt && (underflow_count != '1)) begin
                    underflow_count <= underflow_count + STAT_CNT_WIDTH'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_util_tx_burst_sched.sv
// Randomized bench for util_tx_burst_sched against a group-level scheduling model.
// Build with UTIL_TX_SCHED_STATS_EN defined to also check the event counters.
module tb_util_tx_burst_sched;

    logic        dac_clk = 1'b0;
    logic        reset;
    logic [63:0] timestamp;
    logic [31:0] timestamp_every;
    logic        s_axis_valid, s_axis_ready, s_axis_xfer_req;
    logic [63:0] s_axis_data;
    logic        m_axis_valid, m_axis_ready;
    logic [63:0] m_axis_data;
    logic        upack_flush, late, underflow;
`ifdef UTIL_TX_SCHED_STATS_EN
    logic [31:0] late_count, underflow_count;
`endif

    util_tx_burst_sched dut (
        .dac_clk         (dac_clk),
        .reset           (reset),
        .timestamp       (timestamp),
        .timestamp_every (timestamp_every),
        .s_axis_valid    (s_axis_valid),
        .s_axis_ready    (s_axis_ready),
        .s_axis_xfer_req (s_axis_xfer_req),
        .s_axis_data     (s_axis_data),
        .m_axis_valid    (m_axis_valid),
        .m_axis_ready    (m_axis_ready),
        .m_axis_data     (m_axis_data),
        .upack_flush     (upack_flush),
        .late            (late),
        .underflow       (underflow)
`ifdef UTIL_TX_SCHED_STATS_EN
        ,
        .late_count      (late_count),
        .underflow_count (underflow_count)
`endif
    );

    always #5 dac_clk = ~dac_clk;

    logic        ts_load = 1'b1;
    logic [63:0] ts_load_val = 64'h1000;
    always @(posedge dac_clk) timestamp <= ts_load ? ts_load_val : timestamp + 64'd1;

    int n_checks = 0, n_pass = 0;
    int obs_late = 0, obs_flush = 0, obs_unf = 0;
    int exp_late = 0, exp_flush = 0, exp_unf = 0;
    int base_late = 0, base_unf = 0;
    int cur_every = 0;
    logic xr_v = 1'b0, rst_v = 1'b1;
    logic hdr_mode = 1'b0;
    logic [63:0] hdr_off = '0;
    logic in_acc, out_acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    endtask

    // One DAC cycle: inputs applied after the falling edge, outputs sampled 1 ns later.
    task automatic drive(input logic sv, input logic [63:0] sd, input logic mr);
        @(negedge dac_clk);
        s_axis_xfer_req = xr_v;
        reset           = rst_v;
        s_axis_valid    = sv;
        m_axis_ready    = mr;
        s_axis_data     = hdr_mode ? timestamp + hdr_off : sd;
        #1;
        in_acc  = s_axis_valid && s_axis_ready;
        out_acc = m_axis_valid && m_axis_ready;
        if (late === 1'b1) obs_late++;
        if (upack_flush === 1'b1) obs_flush++;
        if (underflow === 1'b1) obs_unf++;
    endtask

    function automatic logic [63:0] new_beat();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] pick_off();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return -64'($urandom_range(1, 20));
            2: return 64'h8000_0000_0000_0000;
            3: return 64'd1;
            default: return 64'($urandom_range(2, 8));
        endcase
    endfunction

    task automatic start_xfer(input int every);
        timestamp_every = every;
        cur_every = every;
        xr_v = 1'b1;
        base_late = exp_late;
        base_unf  = exp_unf;
        drive(1'b0, '0, 1'b0);
        check("idle_ready", s_axis_ready, 1'b0);
    endtask

    task automatic end_xfer();
        xr_v = 1'b0;
        drive(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b0);
        check("late_total", obs_late, exp_late);
        check("flush_total", obs_flush, exp_flush);
        check("underflow_total", obs_unf, exp_unf);
`ifdef UTIL_TX_SCHED_STATS_EN
        check("late_count", late_count, exp_late - base_late);
        check("underflow_count", underflow_count, exp_unf - base_unf);
`endif
    endtask

    task automatic bypass_run(input int n);
        logic [63:0] q[$];
        logic [63:0] beat, want;
        logic        sv, mr, err;
        int          k, n_out, cyc;
        k = 0; n_out = 0; cyc = 0; err = 1'b0;
        beat = {16'(4*k+4), 16'(4*k+3), 16'(4*k+2), 16'(4*k+1)};
        while (n_out < n && cyc < 400) begin
            sv = (k < n) && ($urandom_range(0, 3) != 0);
            mr = ($urandom_range(0, 3) != 0);
            drive(sv, beat, mr);
            if (m_axis_valid !== sv || s_axis_ready !== mr) err = 1'b1;
            if (in_acc) begin
                q.push_back(beat);
                k++;
                beat = {16'(4*k+4), 16'(4*k+3), 16'(4*k+2), 16'(4*k+1)};
            end
            if (out_acc) begin
                n_out++;
                if (q.size() == 0) err = 1'b1;
                else begin
                    want = q.pop_front();
                    check("bypass_data", m_axis_data, want);
                end
            end
            cyc++;
        end
        check("bypass_beats", n_out, n);
        check("bypass_mirror", err, 1'b0);
    endtask

    // mode: 0 normal, 1 valid gap of 3 after first beat, 2 abort by xfer_req, 3 abort by reset
    task automatic run_group(input logic [63:0] off, input int mode, input int next_every);
        logic [63:0] q[$];
        logic [63:0] h, beat, want, nts;
        logic        sv, mr, rel, started, err_hold, err_mir, err_drop;
        int          n_in, n_out, cyc, rel_idx;
        hdr_mode = 1'b1;
        hdr_off  = off;
        drive(1'b1, '0, 1'b1);
        for (int g = 0; g < 3 && !in_acc; g++) drive(1'b1, '0, 1'b1);
        hdr_mode = 1'b0;
        check("hdr_accept", in_acc, 1'b1);
        h = s_axis_data;
        timestamp_every = next_every;
        n_in = 0; n_out = 0; cyc = 0; rel_idx = 0;
        started = 1'b0; err_hold = 1'b0; err_mir = 1'b0; err_drop = 1'b0;
        beat = new_beat();
        if ($signed(off) <= 0) begin
            exp_late++;
            exp_flush++;
            while (n_in < cur_every && cyc < 200) begin
                sv = ($urandom_range(0, 3) != 0);
                drive(sv, beat, 1'($urandom_range(0, 1)));
                if (cyc == 0) begin
                    check("late_pulse", late, 1'b1);
                    check("late_flush", upack_flush, 1'b1);
                end
                if (!s_axis_ready || m_axis_valid) err_drop = 1'b1;
                if (in_acc) begin
                    n_in++;
                    beat = new_beat();
                end
                cyc++;
            end
            check("drop_beats", n_in, cur_every);
            check("drop_hold", err_drop, 1'b0);
            cur_every = next_every;
            return;
        end
        while (n_in < cur_every && cyc < 300) begin
            if (mode >= 2 && n_in == 2) break;
            nts = timestamp + 64'd1;
            rel = started || (nts == h);
            if (!rel || !started) begin
                sv = 1'b1; mr = 1'b1;
            end else if (mode == 1 && rel_idx >= 1 && rel_idx <= 3) begin
                sv = 1'b0; mr = 1'b1;
            end else begin
                sv = ($urandom_range(0, 3) != 0);
                mr = ($urandom_range(0, 3) != 0);
            end
            drive(sv, beat, mr);
            if (!rel) begin
                if (s_axis_ready || m_axis_valid) err_hold = 1'b1;
            end else begin
                if (!started) begin
                    started = 1'b1;
                    check("first_beat_at_hdr_ts", out_acc, 1'b1);
                end
                if (m_axis_valid !== sv || s_axis_ready !== mr) err_mir = 1'b1;
                if (mr && !sv) exp_unf++;
                rel_idx++;
            end
            if (in_acc) begin
                q.push_back(beat);
                n_in++;
                beat = new_beat();
            end
            if (out_acc) begin
                n_out++;
                if (q.size() == 0) err_mir = 1'b1;
                else begin
                    want = q.pop_front();
                    check("beat_data", m_axis_data, want);
                end
            end
            cyc++;
        end
        check("wait_hold", err_hold, 1'b0);
        check("pass_mirror", err_mir, 1'b0);
        if (mode == 2) begin
            xr_v = 1'b0;
            drive(1'b0, '0, 1'b0);
            exp_flush++;
            drive(1'b0, '0, 1'b0);
            check("abort_flush", upack_flush, 1'b1);
            check("abort_idle_ready", s_axis_ready, 1'b0);
        end else if (mode == 3) begin
            xr_v  = 1'b0;
            rst_v = 1'b1;
            drive(1'b0, '0, 1'b0);
            rst_v = 1'b0;
            drive(1'b0, '0, 1'b0);
            base_late = exp_late;
            base_unf  = exp_unf;
            check("reset_no_flush", upack_flush, 1'b0);
            check("reset_no_late", late, 1'b0);
            check("reset_ready", s_axis_ready, 1'b0);
        end else begin
            check("group_in", n_in, cur_every);
            check("group_out", n_out, cur_every);
            cur_every = next_every;
        end
    endtask

    initial begin
        reset = 1'b1;
        s_axis_xfer_req = 1'b0;
        s_axis_valid = 1'b0;
        s_axis_data = '0;
        m_axis_ready = 1'b0;
        timestamp_every = '0;

        repeat (3) drive(1'b0, '0, 1'b0);
        rst_v = 1'b0;
        ts_load = 1'b0;
        drive(1'b0, '0, 1'b1);
        check("rst_s_ready", s_axis_ready, 1'b0);
        check("rst_m_valid", m_axis_valid, 1'b0);
        check("rst_flush", upack_flush, 1'b0);
        check("rst_late", late, 1'b0);
        check("rst_underflow", underflow, 1'b0);

        start_xfer(0);
        bypass_run(12);
        end_xfer();

        start_xfer(4);
        run_group(64'd1, 0, 4);
        run_group(64'd5, 0, 4);
        run_group(64'd0, 0, 4);
        run_group(64'd3, 0, 4);
        run_group(64'd2, 1, 4);
        end_xfer();

        start_xfer(4);
        run_group(64'd1, 2, 4);
        end_xfer();

        ts_load = 1'b1;
        ts_load_val = 64'hFFFF_FFFF_FFFF_FFFD;
        start_xfer(4);
        ts_load = 1'b0;
        run_group(64'd1, 0, 4);
        run_group(64'd3, 0, 2);
        run_group(64'hFFFF_FFFF_FFFF_FFFF, 0, 3);
        run_group(64'd2, 0, 3);
        end_xfer();

        for (int t = 0; t < 6; t++) begin
            if (t == 3) begin
                ts_load = 1'b1;
                ts_load_val = 64'hFFFF_FFFF_FFFF_FFF6;
            end
            start_xfer($urandom_range(1, 5));
            ts_load = 1'b0;
            for (int g = 0; g < 4; g++) run_group(pick_off(), 0, $urandom_range(1, 5));
            end_xfer();
        end

        start_xfer(4);
        run_group(64'd2, 3, 4);
        end_xfer();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
